useq_controller: RTL

//  Parametrised microprogram sequencer; next generation of the team's 12-bit, 6-deep sequencer.
//  - Generic address width and stack depth.
//  - Adds async reset, empty and error flags, and an optional stall input.
//  - Drives microcode ROM address Y each cycle from I, condition and internal state.
//  - Sits between the pipeline register/map PROM/vector PROM and the control store.

---
 rtl/useq_pkg.sv | 34 +++
 rtl/useq_stack.sv | 55 +++++
 rtl/useq_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/useq_pkg.sv
// Shared types for the microprogram sequencer: opcode set, Y-source select and default geometry.
package useq_pkg;

    localparam int USEQ_AW    = 12;
    localparam int USEQ_DEPTH = 6;

    typedef enum logic [3:0] {
        JZ   = 4'd0,
        CJS  = 4'd1,
        JMAP = 4'd2,
        CJP  = 4'd3,
        PUSH = 4'd4,
        JSRP = 4'd5,
        CJV  = 4'd6,
        JRP  = 4'd7,
        RFCT = 4'd8,
        RPCT = 4'd9,
        CRTN = 4'd10,
        CJPP = 4'd11,
        LDCT = 4'd12,
        LOOP = 4'd13,
        CONT = 4'd14,
        TWB  = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        YSEL_ZERO,
        YSEL_TOP,
        YSEL_UPC,
        YSEL_D,
        YSEL_CNT
    } ysel_t;

endpackage

// File: rtl/useq_stack.sv
// Subroutine/loop LIFO for the sequencer; flags misuse instead of corrupting its contents.
module useq_stack
    import useq_pkg::*;
#(
    parameter int AW    = USEQ_AW,
    parameter int DEPTH = USEQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty,
    output logic          err_push,
    output logic          err_pop
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);

    logic [AW-1:0]  mem [DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_dec;

    assign sp_dec   = sp - SPW'(1);
    assign full     = (sp == SPW'(DEPTH));
    assign empty    = (sp == '0);
    assign top      = empty ? '0 : mem[sp_dec[IW-1:0]];
    assign err_push = push & full & ~clear;
    assign err_pop  = pop & empty & ~clear;

    // A rejected push or pop leaves both the words and the occupancy untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[IW'(k)] <= '0;
            end
        end else if (en) begin
            if (clear) begin
                sp <= '0;
            end else if (push && !full) begin
                mem[sp[IW-1:0]] <= din;
                sp              <= sp + SPW'(1);
            end else if (pop && !empty) begin
                sp <= sp_dec;
            end
        end
    end

endmodule

// File: rtl/useq_controller.sv
// Parametrised 2910-style microprogram sequencer: decode, Y mux, uPC and loop counter.
// Optional stall input nHOLD is present only when USEQ_HOLD_EN is defined.
module useq_controller
    import useq_pkg::*;
#(
    parameter int AW    = USEQ_AW,
    parameter int DEPTH = USEQ_DEPTH
) (
    input  logic          clk,
    input  logic          nRESET,
    input  logic [3:0]    I,
    input  logic          nCCEN,
    input  logic          nCC,
    input  logic          nRLD,
    input  logic          CI,
    input  logic [AW-1:0] D,
`ifdef USEQ_HOLD_EN
    input  logic          nHOLD,
`endif
    output logic [AW-1:0] Y,
    output logic          nPL,
    output logic          nMAP,
    output logic          nVECT,
    output logic          nFULL,
    output logic          nEMPTY,
    output logic          ERR
);

    opcode_t       op;
    ysel_t         ysel;
    logic          pass;
    logic          cnt_zero;
    logic          advance;
    logic          push;
    logic          pop;
    logic          clear;
    logic          load;
    logic          dec;
    logic [AW-1:0] upc;
    logic [AW-1:0] cnt;
    logic [AW-1:0] stack_top;
    logic          full;
    logic          empty;
    logic          err_push;
    logic          err_pop;
    logic          err_flag;

    assign op       = opcode_t'(I);
    assign pass     = ~(nCC & ~nCCEN);
    assign cnt_zero = (cnt == '0);

`ifdef USEQ_HOLD_EN
    assign advance = nHOLD;
`else
    assign advance = 1'b1;
`endif

    // Instruction decode: Y source, stack/counter actions and PROM enables.
    always_comb begin
        ysel  = YSEL_UPC;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        load  = 1'b0;
        dec   = 1'b0;
        nPL   = 1'b0;
        nMAP  = 1'b1;
        nVECT = 1'b1;
        case (op)
            JZ: begin
                ysel  = YSEL_ZERO;
                clear = 1'b1;
            end
            CJS: begin
                if (pass) begin
                    ysel = YSEL_D;
                    push = 1'b1;
                end
            end
            JMAP: begin
                ysel = YSEL_D;
                nMAP = 1'b0;
                nPL  = 1'b1;
            end
            CJP: begin
                if (pass) ysel = YSEL_D;
            end
            PUSH: begin
                push = 1'b1;
                load = pass;
            end
            JSRP: begin
                ysel = pass ? YSEL_D : YSEL_CNT;
                push = 1'b1;
            end
            CJV: begin
                if (pass) ysel = YSEL_D;
                nVECT = 1'b0;
                nPL   = 1'b1;
            end
            JRP: begin
                ysel = pass ? YSEL_D : YSEL_CNT;
            end
            RFCT: begin
                if (!cnt_zero) begin
                    ysel = YSEL_TOP;
                    dec  = 1'b1;
                end else begin
                    pop = 1'b1;
                end
            end
            RPCT: begin
                if (!cnt_zero) begin
                    ysel = YSEL_D;
                    dec  = 1'b1;
                end
            end
            CRTN: begin
                if (pass) begin
                    ysel = YSEL_TOP;
                    pop  = 1'b1;
                end
            end
            CJPP: begin
                if (pass) begin
                    ysel = YSEL_D;
                    pop  = 1'b1;
                end
            end
            LDCT: begin
                load = 1'b1;
            end
            LOOP: begin
                if (pass) pop = 1'b1;
                else      ysel = YSEL_TOP;
            end
            CONT: begin
                ysel = YSEL_UPC;
            end
            TWB: begin
                // Count not exhausted: loop on stack top until the condition passes.
                if (!cnt_zero) begin
                    dec = 1'b1;
                    if (pass) pop = 1'b1;
                    else      ysel = YSEL_TOP;
                end else begin
                    pop  = 1'b1;
                    ysel = pass ? YSEL_UPC : YSEL_D;
                end
            end
            default: begin
                ysel = YSEL_UPC;
            end
        endcase
    end

    always_comb begin
        Y = '0;
        case (ysel)
            YSEL_CNT:  Y = cnt;
            YSEL_D:    Y = D;
            YSEL_UPC:  Y = upc;
            YSEL_TOP:  Y = stack_top;
            default:   Y = '0;
        endcase
    end

    // The external reload strobe takes precedence over any decrement.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            upc      <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
        end else if (advance) begin
            upc <= Y + AW'(CI);
            if (!nRLD || load) begin
                cnt <= D;
            end else if (dec && !cnt_zero) begin
                cnt <= cnt - AW'(1);
            end
            if (clear) begin
                err_flag <= 1'b0;
            end else if (err_push || err_pop) begin
                err_flag <= 1'b1;
            end
        end
    end

    useq_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst_n    (nRESET),
        .en       (advance),
        .push     (push),
        .pop      (pop),
        .clear    (clear),
        .din      (upc),
        .top      (stack_top),
        .full     (full),
        .empty    (empty),
        .err_push (err_push),
        .err_pop  (err_pop)
    );

    assign nFULL  = ~full;
    assign nEMPTY = ~empty;
    assign ERR    = err_flag;

endmodule
